// File: rtl/peer_link_rx_pkg.sv
// Shared definitions for the peer-board link receiver.
//   filt_state_e      : per-word filter FSM state
//   POWER_W           : width of the peer power bus
//   STABLE_CYCLES_DEF : default number of identical samples before a commit
package peer_link_rx_pkg;

    typedef enum logic {
        StStable = 1'b0,  // synced value equals committed value
        StSettle = 1'b1   // synced value differs; counting a candidate
    } filt_state_e;

    localparam int unsigned POWER_W           = 5;
    localparam int unsigned STABLE_CYCLES_DEF = 1024;

endpackage

// File: rtl/link_word_filter.sv
// Synchronizer plus persistence filter for one word of the peer link.
// A new value is committed only after STABLE_CYCLES consecutive identical
// synchronized samples; shorter excursions are discarded.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous input word
//   value      : committed word
//   commit     : one-cycle pulse in the cycle value changes
//   glitch     : combinational pulse when a settle ends without a commit
module link_word_filter
    import peer_link_rx_pkg::*;
#(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] value,
    output logic             commit,
    output logic             glitch
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    // sync_q[0] is the first stage; the last stage feeds the filter.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  synced;

    filt_state_e      state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit_q, commit_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            state_q  <= StStable;
            cand_q   <= '0;
            value_q  <= '0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q  <= state_d;
            cand_q   <= cand_d;
            value_q  <= value_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        value_d  = value_q;
        cnt_d    = cnt_q;
        commit_d = 1'b0;
        glitch   = 1'b0;

        unique case (state_q)
            StStable: begin
                if (synced != value_q) begin
                    cand_d  = synced;
                    cnt_d   = CNT_W'(1);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (synced == value_q) begin
                    cnt_d   = '0;
                    state_d = StStable;
                    glitch  = 1'b1;
                end else if (synced != cand_q) begin
                    cand_d = synced;
                    cnt_d  = CNT_W'(1);
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StStable;
        endcase

        // Commit on the edge where the count reaches its target, so the total
        // latency is the synchronizer depth plus STABLE_CYCLES.
        if (state_d == StSettle && cnt_d == CNT_MAX) begin
            value_d  = cand_d;
            commit_d = 1'b1;
            cnt_d    = '0;
            state_d  = StStable;
        end
    end

    assign value  = value_q;
    assign commit = commit_q;

endmodule

// File: rtl/peer_link_rx.sv
// Receiver for the asynchronous peer-board status lines. Each word (power bus,
// two ready lines, throw line) is synchronized and persistence-filtered
// independently by a link_word_filter.
// Optional feature: define PEER_LINK_GLITCH_CNT_EN to add glitch_cnt, a
// saturating count of filter settles that ended without a commit.
// Ports:
//   clk60MHz, rst_n                  : clock, asynchronous active-low reset
//   in_player1_ready/in_player2_ready: raw ready lines
//   in_power[4:0], in_throw_flag     : raw power bus and throw level
//   player1_ready, player2_ready     : committed ready levels
//   power, power_valid               : committed power word, change pulse
//   throw_flag, throw_rise/fall      : committed throw level and edge pulses
//   glitch_cnt[7:0]                  : only with PEER_LINK_GLITCH_CNT_EN
module peer_link_rx
    import peer_link_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic               clk60MHz,
    input  logic               rst_n,
    input  logic               in_player1_ready,
    input  logic               in_player2_ready,
    input  logic [POWER_W-1:0] in_power,
    input  logic               in_throw_flag,
    output logic               player1_ready,
    output logic               player2_ready,
    output logic [POWER_W-1:0] power,
    output logic               power_valid,
    output logic               throw_flag,
    output logic               throw_rise,
    output logic               throw_fall
`ifdef PEER_LINK_GLITCH_CNT_EN
    ,
    output logic [7:0]         glitch_cnt
`endif
);

    // Index: 0 power, 1 player1, 2 player2, 3 throw.
    logic [3:0] commit_w;
    logic [3:0] glitch_w;

    link_word_filter #(
        .WIDTH        (POWER_W),
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_power (
        .clk   (clk60MHz),
        .rst_n (rst_n),
        .raw   (in_power),
        .value (power),
        .commit(commit_w[0]),
        .glitch(glitch_w[0])
    );

    link_word_filter #(
        .WIDTH        (1),
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_player1 (
        .clk   (clk60MHz),
        .rst_n (rst_n),
        .raw   (in_player1_ready),
        .value (player1_ready),
        .commit(commit_w[1]),
        .glitch(glitch_w[1])
    );

    link_word_filter #(
        .WIDTH        (1),
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_player2 (
        .clk   (clk60MHz),
        .rst_n (rst_n),
        .raw   (in_player2_ready),
        .value (player2_ready),
        .commit(commit_w[2]),
        .glitch(glitch_w[2])
    );

    link_word_filter #(
        .WIDTH        (1),
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_throw (
        .clk   (clk60MHz),
        .rst_n (rst_n),
        .raw   (in_throw_flag),
        .value (throw_flag),
        .commit(commit_w[3]),
        .glitch(glitch_w[3])
    );

    // A commit always changes the value, so the new level gives the edge direction.
    assign power_valid = commit_w[0];
    assign throw_rise  = commit_w[3] & throw_flag;
    assign throw_fall  = commit_w[3] & ~throw_flag;

    // Ready lines expose levels only.
    logic unused_ready_commit;
    assign unused_ready_commit = commit_w[1] ^ commit_w[2];

`ifdef PEER_LINK_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_q, glitch_cnt_d;
    logic [8:0] glitch_sum;

    always_comb begin
        glitch_sum = {1'b0, glitch_cnt_q} + 9'(glitch_w[0]) + 9'(glitch_w[1])
                   + 9'(glitch_w[2]) + 9'(glitch_w[3]);
        glitch_cnt_d = (glitch_sum > 9'd255) ? 8'hFF : glitch_sum[7:0];
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    logic unused_glitch;
    assign unused_glitch = ^glitch_w;
`endif

endmodule

// File: tb/tb_peer_link_rx.sv
`timescale 1ns / 1ps
module tb_peer_link_rx;

    localparam int SYNC = 2;
    localparam int NST  = 1024;
    localparam int LAT  = SYNC + NST;

    logic       clk60MHz = 1'b0;
    logic       rst_n;
    logic       in_player1_ready, in_player2_ready, in_throw_flag;
    logic [4:0] in_power;
    logic       player1_ready, player2_ready, power_valid;
    logic       throw_flag, throw_rise, throw_fall;
    logic [4:0] power;
`ifdef PEER_LINK_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    peer_link_rx #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(NST)
    ) dut (
        .clk60MHz        (clk60MHz),
        .rst_n           (rst_n),
        .in_player1_ready(in_player1_ready),
        .in_player2_ready(in_player2_ready),
        .in_power        (in_power),
        .in_throw_flag   (in_throw_flag),
        .player1_ready   (player1_ready),
        .player2_ready   (player2_ready),
        .power           (power),
        .power_valid     (power_valid),
        .throw_flag      (throw_flag),
        .throw_rise      (throw_rise),
        .throw_fall      (throw_fall)
`ifdef PEER_LINK_GLITCH_CNT_EN
        ,
        .glitch_cnt      (glitch_cnt)
`endif
    );

    always #8 clk60MHz = ~clk60MHz;

    // Reference model: each word is a delay line of SYNC samples followed by a
    // run-length rule: a value commits once it has been the sampled value for
    // NST consecutive edges and differs from the committed value.
    logic [4:0] m_pipe [4][SYNC];
    logic [4:0] m_last [4];
    int         m_run  [4];
    logic [4:0] m_com  [4];
    logic [4:0] m_prev [4];
    logic       m_chg  [4];
    int         m_glitch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] word_raw(input int w);
        case (w)
            0:       return in_power;
            1:       return {4'b0, in_player1_ready};
            2:       return {4'b0, in_player2_ready};
            default: return {4'b0, in_throw_flag};
        endcase
    endfunction

    task automatic model_step();
        logic [4:0] s;
        for (int w = 0; w < 4; w++) begin
            if (!rst_n) begin
                for (int k = 0; k < SYNC; k++) m_pipe[w][k] = '0;
                m_last[w] = '0; m_run[w] = 0; m_com[w] = '0; m_prev[w] = '0; m_chg[w] = 1'b0;
            end else begin
                s = m_pipe[w][SYNC-1];
                for (int k = SYNC - 1; k > 0; k--) m_pipe[w][k] = m_pipe[w][k-1];
                m_pipe[w][0] = word_raw(w);
                // A mismatch run that falls back to the committed value is a glitch.
                if (s == m_com[w] && m_prev[w] != m_com[w] && m_glitch < 255) m_glitch++;
                if (s == m_last[w]) m_run[w]++;
                else begin
                    m_run[w]  = 1;
                    m_last[w] = s;
                end
                m_chg[w] = 1'b0;
                if (m_run[w] >= NST && s != m_com[w]) begin
                    m_com[w] = s;
                    m_chg[w] = 1'b1;
                end
                m_prev[w] = s;
            end
        end
        if (!rst_n) m_glitch = 0;
    endtask

    // One clock: model updates on the edge, outputs are compared mid-cycle.
    task automatic step();
        logic [10:0] act, exp;
        @(posedge clk60MHz);
        model_step();
        @(negedge clk60MHz);
        act = {power, power_valid, player1_ready, player2_ready, throw_flag, throw_rise,
               throw_fall};
        exp = {m_com[0], m_chg[0], m_com[1][0], m_com[2][0], m_com[3][0],
               m_chg[3] & m_com[3][0], m_chg[3] & ~m_com[3][0]};
        chk("model_cycle", 32'(act), 32'(exp));
`ifdef PEER_LINK_GLITCH_CNT_EN
        chk("model_glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
`endif
    endtask

    function automatic logic evt(input int sel);
        case (sel)
            0:       return power_valid;
            1:       return throw_rise;
            default: return throw_fall;
        endcase
    endfunction

    // Steps until the selected pulse is seen; n = cycles taken, -1 on timeout.
    task automatic wait_evt(input int sel, output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            n++;
            if (evt(sel)) return;
        end
        n = -1;
    endtask

    task automatic set_in(input logic [4:0] pw, input logic p1, input logic p2, input logic th);
        in_power = pw; in_player1_ready = p1; in_player2_ready = p2; in_throw_flag = th;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0] pw;
        logic       p1, p2, th;
        int         hold;
        logic [4:0] e_pw;
        logic       e_p1, e_p2, e_th;
    } vec_t;

    vec_t vecs[8];
    int   n;
    logic seen;

    initial begin
        vecs[0] = '{5'd17, 1'b0, 1'b0, 1'b0, 1030, 5'd17, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{5'd17, 1'b1, 1'b0, 1'b0, 1030, 5'd17, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{5'd3,  1'b1, 1'b1, 1'b1, 1030, 5'd3,  1'b1, 1'b1, 1'b1};
        vecs[3] = '{5'd9,  1'b0, 1'b0, 1'b0, 800,  5'd3,  1'b1, 1'b1, 1'b1};
        vecs[4] = '{5'd3,  1'b1, 1'b1, 1'b1, 1030, 5'd3,  1'b1, 1'b1, 1'b1};
        vecs[5] = '{5'd0,  1'b1, 1'b0, 1'b1, 1025, 5'd3,  1'b1, 1'b1, 1'b1};
        vecs[6] = '{5'd0,  1'b1, 1'b0, 1'b1, 1,    5'd0,  1'b1, 1'b0, 1'b1};
        vecs[7] = '{5'd31, 1'b1, 1'b1, 1'b0, 1026, 5'd31, 1'b1, 1'b1, 1'b0};

        // Reset with every raw input high: outputs stay 0 until the filters commit.
        rst_n = 1'b0;
        set_in(5'd31, 1'b1, 1'b1, 1'b1);
        #1;
        chk("rst_outputs_async", 32'({power, power_valid, player1_ready, player2_ready,
                                      throw_flag, throw_rise, throw_fall}), 32'd0);
        repeat (4) step();
        chk("rst_outputs_held", 32'({power, power_valid, player1_ready, player2_ready,
                                     throw_flag, throw_rise, throw_fall}), 32'd0);
        rst_n = 1'b1;
        wait_evt(0, n);
        chk("rst_release_latency", 32'(n), 32'(LAT));
        chk("rst_release_power", 32'(power), 32'd31);
        chk("rst_release_levels", 32'({player1_ready, player2_ready, throw_flag, throw_rise}),
            32'hF);
        step();
        chk("rst_pulses_one_cycle", 32'({power_valid, throw_rise}), 32'd0);

        // Clean step 0 -> 17.
        do_reset();
        in_power = 5'd17;
        wait_evt(0, n);
        chk("step_latency", 32'(n), 32'(LAT));
        chk("step_power", 32'(power), 32'd17);

        // Short throw pulse must be filtered out.
        do_reset();
        seen = 1'b0;
        in_throw_flag = 1'b1;
        repeat (500) begin step(); seen |= throw_flag | throw_rise | throw_fall; end
        in_throw_flag = 1'b0;
        repeat (1100) begin step(); seen |= throw_flag | throw_rise | throw_fall; end
        chk("glitch_quiet", 32'(seen), 32'd0);
`ifdef PEER_LINK_GLITCH_CNT_EN
        chk("glitch_count", 32'(glitch_cnt), 32'd1);
`endif

        // Skewed power bus: bits arrive one per cycle, one commit of 31.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            in_power[b] = 1'b1;
            step();
        end
        in_power[4] = 1'b1;
        wait_evt(0, n);
        chk("skew_latency", 32'(n), 32'(LAT));
        chk("skew_power", 32'(power), 32'd31);
        seen = 1'b0;
        repeat (50) begin step(); seen |= power_valid; end
        chk("skew_single_commit", 32'(seen), 32'd0);

        // Independent words commit together.
        do_reset();
        set_in(5'd0, 1'b1, 1'b1, 1'b1);
        wait_evt(1, n);
        chk("indep_latency", 32'(n), 32'(LAT));
        chk("indep_levels", 32'({player1_ready, player2_ready, throw_flag}), 32'h7);
        step();
        chk("indep_rise_one_cycle", 32'(throw_rise), 32'd0);
        in_throw_flag = 1'b0;
        wait_evt(2, n);
        chk("indep_fall_latency", 32'(n), 32'(LAT));
        chk("indep_fall_level", 32'({player1_ready, player2_ready, throw_flag}), 32'h6);

        // Reset in the middle of a settle discards the partial count.
        do_reset();
        in_power = 5'd9;
        repeat (SYNC + 600) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 32'({power, power_valid}), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("midrst_no_first_pulse", 32'(power_valid), 32'd0);
        wait_evt(0, n);
        chk("midrst_latency", 32'(n + 1), 32'(LAT));
        chk("midrst_power", 32'(power), 32'd9);

        // Table of held input patterns with expected committed outputs.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].pw, vecs[i].p1, vecs[i].p2, vecs[i].th);
            repeat (vecs[i].hold) step();
            chk($sformatf("vec%0d", i), 32'({power, player1_ready, player2_ready, throw_flag}),
                32'({vecs[i].e_pw, vecs[i].e_p1, vecs[i].e_p2, vecs[i].e_th}));
        end

        // Randomized holds and glitches against the model.
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 1) == 0) in_power = 5'($urandom);
            if ($urandom_range(0, 2) == 0) in_player1_ready = ~in_player1_ready;
            if ($urandom_range(0, 2) == 0) in_player2_ready = ~in_player2_ready;
            if ($urandom_range(0, 2) == 0) in_throw_flag = ~in_throw_flag;
            repeat ($urandom_range(1, 1400)) begin
                if ($urandom_range(0, 199) == 0) in_power[$urandom_range(0, 4)] ^= 1'b1;
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
